neopixel_frame_seq: RTL

Frame sequencer that sits directly upstream of the single-pixel NeoPixel transmitter. It holds a per-pixel colour frame buffer written by the host. On request it streams each pixel's 24-bit GRB word into the transmitter, one start/busy handshake per pixel, and then enforces the strip's latch (reset) gap. It replaces broadcast-colour chaining: every pixel in the strip gets its own value.

---
 rtl/neopixel_frame_seq_pkg.sv | 22 ++
 rtl/neopixel_frame_ram.sv | 27 ++
 rtl/neopixel_frame_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/neopixel_frame_seq_pkg.sv
// Shared definitions for the NeoPixel frame sequencer: pixel word width,
// default latch gap and the sequencer state encoding.
package neopixel_frame_seq_pkg;

    localparam int PIXEL_W              = 24;
    localparam int DEFAULT_LATCH_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_ACK   = 3'd3,
        ST_TXW   = 3'd4,
        ST_LATCH = 3'd5
    } seq_state_t;

    // Address width needed to index a buffer of the given depth (never 0).
    function automatic int ram_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/neopixel_frame_ram.sv
// Per-pixel colour store: synchronous write, one-cycle registered read.
// Contents start at zero and have no reset, so they survive rst.
module neopixel_frame_ram
    import neopixel_frame_seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk_16MHz,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [PIXEL_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [PIXEL_W-1:0] rdata
);

    logic [PIXEL_W-1:0] mem [DEPTH] = '{default: '0};

    // Write port and registered read port; a same-address read returns the old word.
    always_ff @(posedge clk_16MHz) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/neopixel_frame_seq.sv
// Frame sequencer for a NeoPixel strip: streams each stored pixel word into
// the single-pixel transmitter, then holds the line idle for the latch gap.
//
// Transmitter handshake: px_start is a request that stays high until px_busy
// is sampled high (the transmitter has taken the word); px_busy falling again
// marks the word as finished. px_data is loaded only in FETCH, so it never
// moves while px_start or px_busy is high.
module neopixel_frame_seq
    import neopixel_frame_seq_pkg::*;
#(
    parameter int NBR_PIXELS   = 8,
    parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
    parameter int ADDR_W       = 8
) (
    input  logic               clk_16MHz,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               frame_start,
    output logic               frame_busy,
    output logic               frame_done,
    output logic [PIXEL_W-1:0] px_data,
    output logic               px_start,
    input  logic               px_busy
);

    localparam int                RAM_AW   = ram_addr_w(NBR_PIXELS);
    localparam int                CNT_W    = $clog2(LATCH_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NBR_PIXELS - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATCH_CYCLES - 1);

    seq_state_t         state;
    logic [ADDR_W-1:0]  idx;
    logic [CNT_W-1:0]   latch_cnt;
    logic [PIXEL_W-1:0] ram_rdata;
    logic               wr_ok;

    // Out-of-range writes are dropped here so they cannot alias onto real pixels.
    assign wr_ok = wr_en && ({1'b0, wr_addr} < (ADDR_W + 1)'(NBR_PIXELS));

    neopixel_frame_ram #(
        .DEPTH  (NBR_PIXELS),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk_16MHz (clk_16MHz),
        .we        (wr_ok),
        .waddr     (wr_addr[RAM_AW-1:0]),
        .wdata     (wr_data),
        .raddr     (idx[RAM_AW-1:0]),
        .rdata     (ram_rdata)
    );

    // Sequencer FSM: one read/present/handshake round per pixel, then the latch gap.
    always_ff @(posedge clk_16MHz) begin
        if (rst) begin
            state      <= ST_IDLE;
            px_start   <= 1'b0;
            px_data    <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            idx        <= '0;
            latch_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        idx   <= '0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // RAM read of idx is in flight this cycle.
                    frame_busy <= 1'b1;
                    state      <= ST_FETCH;
                end
                ST_FETCH: begin
                    px_data  <= ram_rdata;
                    px_start <= 1'b1;
                    state    <= ST_ACK;
                end
                ST_ACK: begin
                    if (px_busy) begin
                        px_start <= 1'b0;
                        state    <= ST_TXW;
                    end
                end
                ST_TXW: begin
                    if (!px_busy) begin
                        if (idx == LAST_IDX) begin
                            latch_cnt <= CNT_LOAD;
                            state     <= ST_LATCH;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LATCH: begin
                    // Loaded with LATCH_CYCLES-1 so done lands LATCH_CYCLES edges after the last word.
                    if (latch_cnt == '0) begin
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        latch_cnt <= latch_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
